// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state encoding and round-robin pick helper for uart_tx_arbiter.
//   state_t  : S_IDLE=00, S_START=01, S_SEND=10, S_GAP=11
//   rr_pick  : first set bit of req searching from ptr+1 (mod n); returns {found, idx}
package uart_arb_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_START = 2'b01, S_SEND = 2'b10, S_GAP = 2'b11} state_t;
  localparam int MAX_REQ = 32;
  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } pick_t;
  // Walks from the farthest candidate to the nearest so the nearest set bit is assigned last.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int i = n; i >= 1; i--) begin
      j = ptr + i;
      if (j >= n) j -= n;
      if (req[j]) begin
        p.found = 1'b1;
        p.idx = 32'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side bus of the UART TX arbiter.
//   req_valid  requester i has a byte pending
//   req_data   byte i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  1-cycle pulse: byte i accepted
//   req_done   1-cycle pulse: byte i fully transmitted
//   master = requester side, slave = arbiter side
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 3, parameter int DATA_WIDTH = 8);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_done;
  modport master (output req_valid, req_data, input req_ready, req_done);
  modport slave (input req_valid, req_data, output req_ready, req_done);
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_valid  pending requests
//   ptr        last granted index (search starts at ptr+1)
//   win        winning index, valid when found
//   found      at least one request pending
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] win,
  output logic                       found
);
  localparam int IW = $clog2(NUM_REQ);
  pick_t p;
  assign p = rr_pick(MAX_REQ'(req_valid), int'(ptr), NUM_REQ);
  assign win = IW'(p.idx);
  assign found = p.found;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX between NUM_REQ byte requesters.
//   clk, rstn    clock, asynchronous active-low reset
//   req          requester bus (slave modport): valid/data in, ready/done pulses out
//   uart_start   start request to the UART TX, held until uart_busy is seen
//   uart_data    byte to the UART TX, held for the whole frame
//   uart_busy    UART TX busy
//   arb_err      1-cycle pulse on watchdog abort
//   grant_id     current or last granted requester
// Optional watchdog built when UART_ARB_TIMEOUT_EN is defined (TIMEOUT_CYC cycles per phase).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 0
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2**20
`endif
) (
  input  logic                       clk,
  input  logic                       rstn,
  uart_tx_arbiter_if.slave           req,
  output logic                       uart_start,
  output logic [DATA_WIDTH-1:0]      uart_data,
  input  logic                       uart_busy,
  output logic                       arb_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t state;
  logic [IW-1:0] ptr, win;
  logic found, wd_hit;
  logic [GW-1:0] gap_cnt;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid(req.req_valid),
    .ptr      (ptr),
    .win      (win),
    .found    (found)
  );
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] wd_cnt;
  assign wd_hit = wd_cnt == TW'(TIMEOUT_CYC - 1);
  // Counts only while a phase keeps waiting, so any state change restarts it from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wd_cnt <= '0;
    else wd_cnt <= ((state == S_START && !uart_busy) || (state == S_SEND && uart_busy)) && !wd_hit ? wd_cnt + TW'(1) : '0;
  end
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      ptr <= IW'(NUM_REQ - 1);
      gap_cnt <= '0;
      uart_start <= 1'b0;
      uart_data <= '0;
      grant_id <= '0;
      arb_err <= 1'b0;
      req.req_ready <= '0;
      req.req_done <= '0;
    end else begin
      req.req_ready <= '0;
      req.req_done <= '0;
      arb_err <= 1'b0;
      case (state)
        // A foreign frame in flight (busy in IDLE) blocks new grants.
        S_IDLE: if (found && !uart_busy) begin
          uart_data <= req.req_data[win*DATA_WIDTH +: DATA_WIDTH];
          grant_id <= win;
          ptr <= win;
          req.req_ready <= NUM_REQ'(1) << win;
          uart_start <= 1'b1;
          state <= S_START;
        end
        S_START: if (wd_hit) begin
          uart_start <= 1'b0;
          arb_err <= 1'b1;
          state <= S_IDLE;
        end else if (uart_busy) begin
          uart_start <= 1'b0;
          state <= S_SEND;
        end
        S_SEND: if (wd_hit) begin
          arb_err <= 1'b1;
          state <= S_IDLE;
        end else if (!uart_busy) begin
          req.req_done <= NUM_REQ'(1) << grant_id;
          gap_cnt <= '0;
          state <= GAP_CYCLES > 0 ? S_GAP : S_IDLE;
        end
        S_GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= S_IDLE;
               else gap_cnt <= gap_cnt + GW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; instance 0 has GAP_CYCLES=0, instance 1 has GAP_CYCLES=5.
module tb_uart_tx_arbiter;
  localparam int N = 3, W = 8;
  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] rv[2], rdy[2], dn[2];
  logic [N*W-1:0] rd[2];
  logic us[2], ub[2], ae[2], fhi[2], flo[2], ln[2];
  logic [W-1:0] ud[2], lat[2];
  logic [1:0] gid[2];
  int tests = 0, fails = 0;
  exp_t rq[2][$], dq[2][$];
  bit open[2], gap_on[2], err_exp[2];
  int gcnt[2];
  exp_t me;

  for (genvar g = 0; g < 2; g++) begin : gen
    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
    logic mb;
    logic [9:0] msh;
    logic [W-1:0] mlat;
    int mcnt;
    assign bus.req_valid = rv[g];
    assign bus.req_data = rd[g];
    assign rdy[g] = bus.req_ready;
    assign dn[g] = bus.req_done;
    assign ub[g] = (mb | fhi[g]) & ~flo[g];
    assign lat[g] = mlat;
    assign ln[g] = mb ? msh[0] : 1'b1;
    uart_tx_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(W), .GAP_CYCLES(5 * g)
`ifdef UART_ARB_TIMEOUT_EN
      , .TIMEOUT_CYC(50)
`endif
    ) dut (
      .clk(clk), .rstn(rstn), .req(bus.slave), .uart_start(us[g]), .uart_data(ud[g]),
      .uart_busy(ub[g]), .arb_err(ae[g]), .grant_id(gid[g])
    );
    // UART TX model: 10 clk per bit, start + 8 data LSB first + stop.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        mb <= 1'b0; mcnt <= 0; msh <= '1; mlat <= '0;
      end else if (!mb) begin
        if (us[g] && !flo[g]) begin
          mb <= 1'b1; mcnt <= 0; msh <= {1'b1, ud[g], 1'b0}; mlat <= ud[g];
        end
      end else begin
        mcnt <= mcnt + 1;
        if (mcnt % 10 == 9) msh <= {1'b1, msh[9:1]};
        if (mcnt == 99) mb <= 1'b0;
      end
    end
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic expect_byte(input int g, input logic [1:0] id, input logic [W-1:0] d, input bit done);
    rq[g].push_back({id, d});
    if (done) dq[g].push_back({id, d});
  endtask

  task automatic serve(input int g, input int c0, input int c1, input int c2);
    int rem[N];
    int t = 0;
    rem[0] = c0; rem[1] = c1; rem[2] = c2;
    for (int i = 0; i < N; i++) rv[g][i] = rem[i] > 0;
    while ((rq[g].size() != 0 || dq[g].size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < N; i++)
        if (rdy[g][i] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) rv[g][i] = 1'b0;
          else rd[g][i*W +: W] = rd[g][i*W +: W] + 8'd1;
        end
    end
    if (t >= 3000) chk("serve_timeout", 1, 0);
  endtask

  task automatic check_zero(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk({nm, "_start"}, 32'(us[g]), 0);
      chk({nm, "_data"}, 32'(ud[g]), 0);
      chk({nm, "_ready"}, 32'(rdy[g]), 0);
      chk({nm, "_done"}, 32'(dn[g]), 0);
      chk({nm, "_err"}, 32'(ae[g]), 0);
      chk({nm, "_gid"}, 32'(gid[g]), 0);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        open[k] = 0; gap_on[k] = 0;
      end else begin
        if (rdy[k] != 0) begin
          chk("done_before_ready", 32'(open[k]), 0);
          open[k] = 1;
          if (rq[k].size() == 0) chk("unexpected_ready", 32'(rdy[k]), 0);
          else begin
            me = rq[k].pop_front();
            chk("ready_id", 32'(rdy[k]), 32'(1) << me.id);
            chk("grant_id", 32'(gid[k]), 32'(me.id));
            chk("uart_data", 32'(ud[k]), 32'(me.data));
          end
        end
        if (dn[k] != 0) begin
          open[k] = 0; gap_on[k] = 1; gcnt[k] = 0;
          if (dq[k].size() == 0) chk("unexpected_done", 32'(dn[k]), 0);
          else begin
            me = dq[k].pop_front();
            chk("done_id", 32'(dn[k]), 32'(1) << me.id);
            chk("data_held", 32'(ud[k]), 32'(me.data));
            chk("uart_latched", 32'(lat[k]), 32'(me.data));
          end
        end else if (gap_on[k]) begin
          if (rv[k] == 0) gap_on[k] = 0;
          else begin
            gcnt[k]++;
            if (us[k]) begin
              chk("gap_cycles", 32'(gcnt[k]), 32'(1 + 5 * k));
              gap_on[k] = 0;
            end
          end
        end
        if (ae[k]) begin
          open[k] = 0;
          chk("arb_err_expected", 32'(err_exp[k]), 1);
          err_exp[k] = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] got;
    int c;
    for (int g = 0; g < 2; g++) begin
      rv[g] = '0; rd[g] = '0; fhi[g] = 0; flo[g] = 0; open[g] = 0; gap_on[g] = 0; err_exp[g] = 0; gcnt[g] = 0;
    end
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    // T2: all three requesting, expected order 0,1,2,0
    rd[0] = {8'h67, 8'h66, 8'h65};
    expect_byte(0, 0, 8'h65, 1); expect_byte(0, 1, 8'h66, 1);
    expect_byte(0, 2, 8'h67, 1); expect_byte(0, 0, 8'h66, 1);
    serve(0, 2, 1, 1);
    // T1: single byte 0x65, check the serial line
    rd[0][7:0] = 8'h65;
    expect_byte(0, 0, 8'h65, 1);
    got = '0;
    fork
      serve(0, 1, 0, 0);
      begin
        c = 0;
        while (!ub[0] && c < 100) begin @(negedge clk); c++; end
        chk("busy_seen", 32'(ub[0]), 1);
        chk("start_held", 32'(us[0]), 1);
        for (int j = 0; j < 100; j++) begin
          if (j == 1) chk("start_dropped", 32'(us[0]), 0);
          if (j % 10 == 5) got[j/10] = ln[0];
          @(negedge clk);
        end
        chk("line_bits", 32'(got), 32'({1'b1, 8'h65, 1'b0}));
      end
    join
    // T3: gap instance, two bytes from requester 1
    rd[1][15:8] = 8'h50;
    expect_byte(1, 1, 8'h50, 1); expect_byte(1, 1, 8'h51, 1);
    serve(1, 0, 2, 0);
    // T6: busy already high, no grant until it drops
    fhi[0] = 1;
    rd[0][23:16] = 8'h3C;
    rv[0] = 3'b100;
    c = 0;
    repeat (20) begin @(negedge clk); if (rdy[0] != 0) c++; end
    chk("no_grant_while_busy", 32'(c), 0);
    expect_byte(0, 2, 8'h3C, 1);
    fhi[0] = 0;
    @(negedge clk);
    chk("grant_after_busy_drop", 32'(rdy[0]), 32'(3'b100));
    rv[0] = '0;
    serve(0, 0, 0, 0);
`ifdef UART_ARB_TIMEOUT_EN
    // T5: UART never responds, watchdog fires after 50 cycles
    flo[0] = 1;
    rd[0][7:0] = 8'h11;
    expect_byte(0, 0, 8'h11, 0);
    rv[0] = 3'b001;
    c = 0;
    while (!rdy[0][0] && c < 100) begin @(negedge clk); c++; end
    rv[0] = '0;
    err_exp[0] = 1;
    c = 0;
    while (!ae[0] && c < 200) begin @(negedge clk); c++; end
    chk("arb_err_latency", 32'(c), 50);
    flo[0] = 0;
    @(negedge clk);
    rd[0][15:8] = 8'h22;
    expect_byte(0, 1, 8'h22, 1);
    serve(0, 0, 1, 0);
`endif
    // T4: reset in the middle of a frame
    rd[0][7:0] = 8'h5A;
    expect_byte(0, 0, 8'h5A, 0);
    rv[0] = 3'b001;
    c = 0;
    while (!ub[0] && c < 100) begin
      @(negedge clk);
      if (rdy[0][0]) rv[0] = '0;
      c++;
    end
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    #1 check_zero("mid_reset");
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rstn = 1'b1;
    @(negedge clk);
    rd[0][15:8] = 8'h42;
    expect_byte(0, 1, 8'h42, 1);
    serve(0, 0, 1, 0);
    repeat (5) @(negedge clk);
    chk("queues_drained", 32'(rq[0].size() + dq[0].size() + rq[1].size() + dq[1].size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
